// File: rtl/snake_move_ctrl.sv
// snake_move_ctrl: snake game-step scheduler (key debounce/arbitration, step tick, head move, req/ack, state, score)
// Ports: sys_clk_50/sys_rst clock and async active-high reset; key raw direction keys (0 up,1 down,2 left,3 right);
// start start/restart pulse; step_req/step_ack step handshake with collide/eaten sampled on ack;
// head_x/head_y head position; dir committed direction; state 0 IDLE 1 RUN 2 WAIT 3 OVER; score saturating food count.
module snake_move_ctrl #(
  parameter int TICK_DIV = 5000000,
  parameter int DEB_CYC  = 1000000,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int XW       = 6,
  parameter int YW       = 5
) (
  input  logic          sys_clk_50,
  input  logic          sys_rst,
  input  logic [3:0]    key,
  input  logic          start,
  output logic          step_req,
  input  logic          step_ack,
  input  logic          collide,
  input  logic          eaten,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    dir,
  output logic [1:0]    state,
  output logic [7:0]    score
);
  localparam int CW = DEB_CYC > 2 ? $clog2(DEB_CYC) : 1;
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [1:0] {IDLE, RUN, WAIT, OVER} state_t;
  state_t        st_q;
  logic [3:0]    key_q;
  logic [CW-1:0] deb_q;
  logic [PW-1:0] pre_q;
  logic [1:0]    pend_q, dir_q;
  logic [XW-1:0] x_q, nx_d;
  logic [YW-1:0] y_q, ny_d;
  logic [7:0]    score_q;
  logic          req_q, acc, take, tc;
  logic [1:0]    cand;
  always_comb begin
    // the accept fires on the edge where the stable count reaches DEB_CYC-1
    acc  = key == key_q && deb_q == CW'(DEB_CYC - 2) && |key_q && (st_q == RUN || st_q == WAIT);
    cand = key_q[0] ? 2'd0 : key_q[1] ? 2'd1 : key_q[2] ? 2'd2 : 2'd3;
    // opposite direction differs only in bit 0
    take = acc && cand != (dir_q ^ 2'd1);
    tc   = st_q == RUN && pre_q == PW'(TICK_DIV - 1);
    nx_d = pend_q == 2'd3 ? (x_q == XW'(GRID_W - 1) ? '0 : x_q + XW'(1)) :
           pend_q == 2'd2 ? (x_q == '0 ? XW'(GRID_W - 1) : x_q - XW'(1)) : x_q;
    ny_d = pend_q == 2'd1 ? (y_q == YW'(GRID_H - 1) ? '0 : y_q + YW'(1)) :
           pend_q == 2'd0 ? (y_q == '0 ? YW'(GRID_H - 1) : y_q - YW'(1)) : y_q;
  end
  always_ff @(posedge sys_clk_50 or posedge sys_rst) begin
    if (sys_rst) begin
      st_q    <= IDLE;
      key_q   <= '0;
      deb_q   <= '0;
      pre_q   <= '0;
      pend_q  <= 2'd3;
      dir_q   <= 2'd3;
      x_q     <= XW'(GRID_W / 2);
      y_q     <= YW'(GRID_H / 2);
      score_q <= '0;
      req_q   <= 1'b0;
    end else begin
      key_q <= key;
      deb_q <= key != key_q ? '0 : deb_q == CW'(DEB_CYC - 1) ? deb_q : deb_q + CW'(1);
      if (take) pend_q <= cand;
      case (st_q)
        IDLE, OVER: if (start) begin
          st_q    <= RUN;
          x_q     <= XW'(GRID_W / 2);
          y_q     <= YW'(GRID_H / 2);
          dir_q   <= 2'd3;
          pend_q  <= 2'd3;
          score_q <= '0;
          pre_q   <= '0;
        end
        RUN: if (tc) begin
          dir_q <= pend_q;
          x_q   <= nx_d;
          y_q   <= ny_d;
          req_q <= 1'b1;
          pre_q <= '0;
          st_q  <= WAIT;
        end else begin
          pre_q <= pre_q + PW'(1);
        end
        WAIT: if (step_ack) begin
          req_q <= 1'b0;
          if (collide) begin
            st_q <= OVER;
          end else begin
            score_q <= score_q == 8'hFF ? score_q : score_q + 8'(eaten);
            st_q    <= RUN;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end
  assign step_req = req_q;
  assign head_x   = x_q;
  assign head_y   = y_q;
  assign dir      = dir_q;
  assign state    = st_q;
  assign score    = score_q;
endmodule

// File: tb/tb_snake_move_ctrl.sv
// tb_snake_move_ctrl: randomized bench for snake_move_ctrl against a timestamp-based game model
module tb_snake_move_ctrl;
  localparam int TICK_DIV = 4, DEB_CYC = 3, GRID_W = 8, GRID_H = 6, XW = 3, YW = 3;
  logic sys_clk_50 = 0, sys_rst = 1, start = 0, step_req, step_ack = 0, collide = 0, eaten = 0;
  logic [3:0] key = 0;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [1:0] dir, state;
  logic [7:0] score;
  int checks = 0, errors = 0;
  int m_st, m_req, m_x, m_y, m_dir, m_pend, m_score, run_start, ksamp, since, e;
  int dx[4] = '{0, 0, -1, 1};
  int dy[4] = '{-1, 1, 0, 0};
  int opp[4] = '{1, 0, 3, 2};
  int hold = 0, did_rst = 0;
  snake_move_ctrl #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC), .GRID_W(GRID_W), .GRID_H(GRID_H),
    .XW(XW), .YW(YW)) dut (
    .sys_clk_50(sys_clk_50), .sys_rst(sys_rst), .key(key), .start(start), .step_req(step_req),
    .step_ack(step_ack), .collide(collide), .eaten(eaten), .head_x(head_x), .head_y(head_y),
    .dir(dir), .state(state), .score(score));
  always #5 sys_clk_50 = ~sys_clk_50;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic m_init();
    m_x = GRID_W / 2; m_y = GRID_H / 2; m_dir = 3; m_pend = 3; m_score = 0;
  endtask
  task automatic m_reset();
    m_st = 0; m_req = 0; m_init(); run_start = 0; ksamp = 0; since = 0; e = 0;
  endtask
  task automatic check_all();
    chk("state", int'(state), m_st);
    chk("step_req", int'(step_req), m_req);
    chk("head_x", int'(head_x), m_x);
    chk("head_y", int'(head_y), m_y);
    chk("dir", int'(dir), m_dir);
    chk("score", int'(score), m_score);
  endtask
  // advance the model by one clock edge using the inputs currently driven
  task automatic m_step();
    int k, cand, newpend, oldpend;
    bit acc;
    e++;
    k = int'(key);
    acc = k == ksamp && e - since == DEB_CYC - 1 && k != 0 && (m_st == 1 || m_st == 2);
    if (k != ksamp) begin ksamp = k; since = e; end
    cand = 3;
    for (int i = 3; i >= 0; i--) if (k[i]) cand = i;
    oldpend = m_pend;
    newpend = (acc && cand != opp[m_dir]) ? cand : m_pend;
    m_pend = newpend;
    case (m_st)
      0, 3: if (start) begin m_init(); m_st = 1; run_start = e; end
      1: if (e - run_start == TICK_DIV) begin
        m_dir = oldpend;
        m_x = (m_x + dx[m_dir] + GRID_W) % GRID_W;
        m_y = (m_y + dy[m_dir] + GRID_H) % GRID_H;
        m_req = 1; m_st = 2;
      end
      default: if (step_ack) begin
        m_req = 0;
        if (collide) m_st = 3;
        else begin
          if (eaten && m_score < 255) m_score++;
          m_st = 1; run_start = e;
        end
      end
    endcase
  endtask
  initial begin
    m_reset();
    repeat (3) @(negedge sys_clk_50);
    check_all();
    sys_rst = 0;
    for (int c = 0; c < 5500; c++) begin
      bit pb;
      pb = c >= 3000;
      @(negedge sys_clk_50);
      if (!pb && c > 500 && m_req == 1 && (!did_rst || $urandom_range(0, 299) == 0)) begin
        did_rst = 1;
        sys_rst = 1;
        #1;
        chk("rst_step_req", int'(step_req), 0);
        chk("rst_state", int'(state), 0);
        @(negedge sys_clk_50);
        sys_rst = 0;
        m_reset();
      end
      check_all();
      if (hold == 0) begin
        int r;
        r = $urandom_range(0, 9);
        key = r < 2 ? 4'd0 : r < 7 ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        hold = $urandom_range(1, 6);
      end
      hold--;
      start = (m_st == 0 || m_st == 3) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 29) == 0;
      if (m_req == 1) begin
        step_ack = pb ? 1'b1 : $urandom_range(0, 2) == 0;
        collide = pb ? 1'b0 : $urandom_range(0, 11) == 0;
        eaten = pb ? 1'b1 : $urandom_range(0, 2) == 0;
      end else begin
        step_ack = $urandom_range(0, 9) == 0;
        collide = pb ? 1'b0 : 1'($urandom_range(0, 1));
        eaten = 1'($urandom_range(0, 1));
      end
      m_step();
    end
    @(negedge sys_clk_50);
    check_all();
    chk("score_sat", int'(score), 255);
    chk("rst_seen", did_rst, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
